router_fsm: RTL and testbench
=============================

# router_fsm

Sequencing controller for the 1x3 router datapath. Watches the incoming packet stream (pkt_valid, header address bits) and FIFO status, and drives the load/phase strobes that the packet register block consumes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg. It also drives the FIFO write-enable gate and the source-side busy flag. It sits between the router top-level input port, the packet register block and the three output FIFOs.

## Interface
- Parameters: none; state encodings live in the shared package.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  source asserts for header and payload bytes; deasserts on the parity byte
- datain  in  2  header address bits [1:0], sampled in DECODE_ADDRESS
- fifo_full  in  1  full flag of the currently addressed FIFO
- fifo_empty_0/1/2  in  1 each  empty flags of output FIFOs 0..2
- soft_reset_0/1/2  in  1 each  per-FIFO timeout soft reset
- parity_done  in  1  from the packet register block: parity byte captured
- low_pkt_valid  in  1  from the packet register block: pkt_valid fell while the FIFO was full
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  one-hot phase strobes
- write_enb_reg  out  1  FIFO write enable
- busy  out  1  source must hold its current byte

## Operation
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Address register addr[1:0] latches datain in DECODE_ADDRESS when pkt_valid=1 and datain!=3.
- Transitions out of DECODE_ADDRESS:
  - pkt_valid, datain=n (n in 0..2), fifo_empty_n=1 -> LOAD_FIRST_DATA.
  - pkt_valid, datain=n, fifo_empty_n=0 -> WAIT_TILL_EMPTY.
  - datain=3 or pkt_valid=0 -> stay. Address 3 is dropped silently.
- WAIT_TILL_EMPTY: stay until fifo_empty_addr=1, then go to LOAD_FIRST_DATA.
- LOAD_FIRST_DATA: always go to LOAD_DATA.
- LOAD_DATA, in priority order:
  - fifo_full -> FIFO_FULL_STATE.
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: stay while fifo_full; when it clears, go to LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: always go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Soft reset: soft_reset_addr=1 (for the latched address only) forces the next state to DECODE_ADDRESS from any state. It overrides every other transition. Soft resets on other ports are ignored.
- Outputs are Moore, decoded from the state register:
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = every state except DECODE_ADDRESS and LOAD_DATA

## Timing
- Reset, asynchronous, while reset=1:
  - state = DECODE_ADDRESS, addr = 0.
  - detect_add = 1; every other output = 0.
- Reset deassertion mid-packet always resumes in DECODE_ADDRESS. The partial packet is abandoned.
- Next state registers on the rising clock edge. Outputs change in the cycle after the qualifying input sample; no combinational input-to-output path.
- Header to first write: header sampled in cycle 0, LOAD_FIRST_DATA in cycle 1, first LOAD_DATA write in cycle 2 (empty FIFO).
- pkt_valid falling in LOAD_DATA: LOAD_PARITY for exactly 1 cycle, then CHECK_PARITY_ERROR for exactly 1 cycle (rst_int_reg pulse).
- fifo_full and !pkt_valid in the same LOAD_DATA cycle: full has priority.
- soft_reset together with any other condition: soft reset wins.

## Structure
- Shared package router_pkg holds:
  - the state enum/localparams (3-bit, binary-encoded);
  - the address constant ADDR_INVALID = 2'd3.
- No sub-module needed. Write as a single state-register process, a next-state combinational block and an output decode.

## Test plan
- Reset: assert reset mid-LOAD_DATA -> immediately state = DECODE_ADDRESS, detect_add=1, busy=0, write_enb_reg=0.
- Normal packet, addr 2, fifo_empty_2=1, 8 payload bytes:
  - detect_add 1 cycle, lfd_state 1 cycle, ld_state 8 cycles, LOAD_PARITY 1 cycle, rst_int_reg 1 cycle, then back to DECODE_ADDRESS.
  - write_enb_reg high for 9 cycles.
- Busy port, header addr 1, fifo_empty_1=0 for 5 cycles: busy=1 in WAIT_TILL_EMPTY for 5 cycles, then lfd_state=1 on the cycle after empty rises.
- Full mid-packet: fifo_full=1 on the 3rd payload byte for 4 cycles -> full_state=1 for 4 cycles, busy=1, laf_state 1 cycle, then ld_state resumes. Repeat with low_pkt_valid=1 -> LAF goes to LOAD_PARITY.
- Soft reset and invalid address:
  - soft_reset_0 during LOAD_DATA on port 0 -> DECODE_ADDRESS next cycle.
  - soft_reset_1 on the same packet -> no effect.
  - Header datain=3 with pkt_valid=1 -> FSM stays in DECODE_ADDRESS, no write.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router sequencing controller: state encodings,
// the dropped header address and a port-select helper.
package router_pkg;

  // 3-bit binary state encodings, kept as plain constants so legacy blocks
  // that compare against raw codes keep working.
  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  // Header address that has no output FIFO; such packets are dropped.
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  localparam int NUM_PORTS = 3;

  // Select the per-port flag for address a; the invalid address selects
  // nothing so it can never qualify a transition.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] v,
                                    input logic [1:0] a);
    case (a)
      2'd0:    port_bit = v[0];
      2'd1:    port_bit = v[1];
      2'd2:    port_bit = v[2];
      default: port_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Handshake/status bundle between the router controller, the input port,
// the packet register block and the output FIFOs.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] datain;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  // Controller side: consumes status, produces phase strobes.
  modport master (
    input  pkt_valid, datain, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output rst_int_reg, write_enb_reg, busy
  );

  // Datapath side: produces status, consumes phase strobes.
  modport slave (
    output pkt_valid, datain, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Router sequencing controller: tracks the packet phase and drives Moore
// load/phase strobes, the FIFO write gate and the source busy flag.
module router_fsm
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  router_fsm_if.master bus
);

  logic [2:0] state, state_nxt;
  logic [1:0] addr;

  logic [NUM_PORTS-1:0] empty_v, srst_v;
  logic hdr_ok, hdr_empty, addr_empty, srst_hit;

  assign empty_v = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_v  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  // Header is usable only when valid and addressed to a real port.
  assign hdr_ok     = bus.pkt_valid && (bus.datain != ADDR_INVALID);
  assign hdr_empty  = port_bit(empty_v, bus.datain);
  assign addr_empty = port_bit(empty_v, addr);
  // Only the timeout of the port we are talking to can abort us.
  assign srst_hit   = port_bit(srst_v, addr);

  // State and latched destination address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && hdr_ok) addr <= bus.datain;
    end
  end

  // Next-state rules; soft reset is applied last so it overrides all.
  always_comb begin
    state_nxt = state;
    case (state)
      DECODE_ADDRESS:
        if (hdr_ok) state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (addr_empty) state_nxt = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        state_nxt = LOAD_DATA;
      LOAD_DATA:
        if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
        else                        state_nxt = LOAD_DATA;
      LOAD_PARITY:
        state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        state_nxt = DECODE_ADDRESS;
    endcase
    if (srst_hit) state_nxt = DECODE_ADDRESS;
  end

  // Moore output decode straight off the state register.
  always_comb begin
    bus.detect_add    = (state == DECODE_ADDRESS);
    bus.lfd_state     = (state == LOAD_FIRST_DATA);
    bus.ld_state      = (state == LOAD_DATA);
    bus.laf_state     = (state == LOAD_AFTER_FULL);
    bus.full_state    = (state == FIFO_FULL_STATE);
    bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
    // Source may only push in address decode and steady payload loading.
    bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios with literal expectations
// plus randomized traffic checked every cycle against a phase-level model.
module tb_router_fsm;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_fsm_if bus();

  router_fsm dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Packet phases as named in the controller description.
  typedef enum int {P_DEC, P_LFD, P_LD, P_FULL, P_LAF, P_LP, P_CPE, P_WAIT} ph_t;

  ph_t      m_ph = P_DEC;
  int       m_port = 0;

  // Expected strobe vector {detect,lfd,ld,laf,full,rst_int,write_enb,busy}.
  function automatic logic [7:0] expect_out(ph_t p);
    logic wr, bsy;
    wr  = (p == P_LD) || (p == P_LP) || (p == P_LAF);
    bsy = !((p == P_DEC) || (p == P_LD));
    return {p == P_DEC, p == P_LFD, p == P_LD, p == P_LAF, p == P_FULL,
            p == P_CPE, wr, bsy};
  endfunction

  // Phase model advanced on each clock edge from the described rules.
  always @(posedge clock or posedge reset) begin
    logic [2:0] emp, sr;
    ph_t nx;
    emp = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    sr  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    if (reset) begin
      m_ph   = P_DEC;
      m_port = 0;
    end else begin
      nx = m_ph;
      if (m_ph == P_DEC) begin
        if (bus.pkt_valid && bus.datain != 2'd3)
          nx = emp[bus.datain] ? P_LFD : P_WAIT;
      end else if (m_ph == P_WAIT) begin
        if (emp[m_port]) nx = P_LFD;
      end else if (m_ph == P_LFD) nx = P_LD;
      else if (m_ph == P_LD) begin
        if (bus.fifo_full) nx = P_FULL;
        else if (!bus.pkt_valid) nx = P_LP;
      end else if (m_ph == P_FULL) begin
        if (!bus.fifo_full) nx = P_LAF;
      end else if (m_ph == P_LAF) begin
        nx = bus.parity_done ? P_DEC : (bus.low_pkt_valid ? P_LP : P_LD);
      end else if (m_ph == P_LP) nx = P_CPE;
      else nx = bus.fifo_full ? P_FULL : P_DEC;
      if (sr[m_port]) nx = P_DEC;
      if (m_ph == P_DEC && bus.pkt_valid && bus.datain != 2'd3)
        m_port = int'(bus.datain);
      m_ph = nx;
    end
  end

  // Per-cycle comparison of every strobe against the model.
  always @(negedge clock) begin
    logic [7:0] got, want;
    got  = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    want = expect_out(m_ph);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL model_cmp t=%0t got=%b want=%b", $time, got, want);
  end

  // Strobe occupancy counters for the directed scenarios.
  int c_ld, c_we, c_lfd, c_rst, c_full, c_laf, c_busy;
  always @(negedge clock) begin
    if (!reset) begin
      c_ld   += int'(bus.ld_state);
      c_we   += int'(bus.write_enb_reg);
      c_lfd  += int'(bus.lfd_state);
      c_rst  += int'(bus.rst_int_reg);
      c_full += int'(bus.full_state);
      c_laf  += int'(bus.laf_state);
      c_busy += int'(bus.busy);
    end
  end

  task automatic clr();
    c_ld = 0; c_we = 0; c_lfd = 0; c_rst = 0; c_full = 0; c_laf = 0; c_busy = 0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.pkt_valid = 0; bus.datain = 0; bus.fifo_full = 0;
    bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
    bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
    bus.parity_done = 0; bus.low_pkt_valid = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    clr();
    #1;
    chk("rst_detect", int'(bus.detect_add), 1);
    chk("rst_we", int'(bus.write_enb_reg), 0);
    tick(); tick();
    reset = 0;
    tick();

    // Normal packet to port 2, 8 payload-load cycles.
    clr();
    bus.pkt_valid = 1; bus.datain = 2'd2;
    tick();                 // LFD
    tick();                 // LD1
    repeat (7) tick();      // LD8
    bus.pkt_valid = 0;
    tick();                 // LP
    tick();                 // CPE
    tick();                 // DEC
    chk("norm_ld", c_ld, 8);
    chk("norm_we", c_we, 9);
    chk("norm_lfd", c_lfd, 1);
    chk("norm_rst", c_rst, 1);
    chk("norm_back", int'(bus.detect_add), 1);

    // Wait for port 1 to drain for 5 cycles.
    idle(); bus.fifo_empty_1 = 0; tick();
    bus.pkt_valid = 1; bus.datain = 2'd1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("wait_busy", int'(bus.busy && !bus.detect_add && !bus.lfd_state), 1);
      if (k < 4) tick();
    end
    bus.fifo_empty_1 = 1;
    tick();
    chk("wait_lfd", int'(bus.lfd_state), 1);
    bus.pkt_valid = 0;
    repeat (4) tick();

    // Full on the 3rd payload byte for 4 cycles, then resume loading.
    idle(); tick(); clr();
    bus.pkt_valid = 1; bus.datain = 2'd0;
    tick(); tick(); tick(); tick();     // LFD, LD1, LD2, LD3
    bus.fifo_full = 1;
    repeat (4) tick();                  // FULL x4
    bus.fifo_full = 0;
    tick();                             // LAF
    tick();                             // LD
    chk("full_ld_resume", int'(bus.ld_state), 1);
    chk("full_cnt", c_full, 4);
    chk("full_laf", c_laf, 1);
    chk("full_busy", c_busy, 6);
    bus.pkt_valid = 0;
    repeat (3) tick();

    // Same, but pkt_valid fell while full: LAF goes to parity.
    idle(); tick();
    bus.pkt_valid = 1; bus.datain = 2'd0;
    tick(); tick(); tick(); tick();
    bus.fifo_full = 1;
    repeat (4) tick();
    bus.fifo_full = 0; bus.low_pkt_valid = 1; bus.pkt_valid = 0;
    tick();                             // LAF
    tick();                             // LP
    chk("lpv_lp", int'(bus.write_enb_reg && !bus.ld_state && !bus.laf_state && bus.busy), 1);
    tick();                             // CPE
    chk("lpv_cpe", int'(bus.rst_int_reg), 1);
    bus.low_pkt_valid = 0;
    tick();

    // Soft reset: other port ignored, own port aborts.
    idle(); tick();
    bus.pkt_valid = 1; bus.datain = 2'd0;
    tick(); tick();                     // LFD, LD
    bus.soft_reset_1 = 1;
    tick();
    chk("srst_other", int'(bus.ld_state), 1);
    bus.soft_reset_1 = 0; bus.soft_reset_0 = 1; bus.pkt_valid = 0;
    tick();
    chk("srst_own", int'(bus.detect_add), 1);
    bus.soft_reset_0 = 0;
    tick();

    // Address 3 is dropped.
    idle(); clr();
    bus.pkt_valid = 1; bus.datain = 2'd3;
    repeat (3) tick();
    chk("inv_we", c_we, 0);
    chk("inv_detect", int'(bus.detect_add), 1);
    idle(); tick();

    // Asynchronous reset in the middle of loading.
    bus.pkt_valid = 1; bus.datain = 2'd2;
    tick(); tick();                     // LFD, LD
    chk("pre_rst_ld", int'(bus.ld_state), 1);
    reset = 1;
    #1;
    chk("arst_detect", int'(bus.detect_add), 1);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_we", int'(bus.write_enb_reg), 0);
    tick();
    idle();
    reset = 0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.pkt_valid     = ($urandom_range(0, 3) != 0);
      bus.datain        = 2'($urandom_range(0, 3));
      bus.fifo_full     = ($urandom_range(0, 3) == 0);
      bus.fifo_empty_0  = ($urandom_range(0, 2) != 0);
      bus.fifo_empty_1  = ($urandom_range(0, 2) != 0);
      bus.fifo_empty_2  = ($urandom_range(0, 2) != 0);
      bus.soft_reset_0  = ($urandom_range(0, 19) == 0);
      bus.soft_reset_1  = ($urandom_range(0, 19) == 0);
      bus.soft_reset_2  = ($urandom_range(0, 19) == 0);
      bus.parity_done   = ($urandom_range(0, 3) == 0);
      bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
      reset             = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
